// File: rtl/mdu_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with sign fix-up in a final cycle before done.
module mdu_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        sgn_a_q, sgn_a_d;
  logic        sgn_b_q, sgn_b_d;
  logic        special_q, special_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;

  // Operand conditioning at accept time.
  logic        in_sgn_a, in_sgn_b, is_div, div_zero, div_ovf;
  logic [31:0] mag_a, mag_b;

  assign is_div   = funct3[2];
  assign in_sgn_a = rs1[31] & ((funct3 == 3'b001) || (funct3 == 3'b010) ||
                               (funct3 == 3'b100) || (funct3 == 3'b110));
  assign in_sgn_b = rs2[31] & ((funct3 == 3'b001) || (funct3 == 3'b100) ||
                               (funct3 == 3'b110));
  assign mag_a    = in_sgn_a ? -rs1 : rs1;
  assign mag_b    = in_sgn_b ? -rs2 : rs2;
  assign div_zero = is_div & (rs2 == 32'd0);
  assign div_ovf  = is_div & ~funct3[0] & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);

  // acc_q holds {product high, multiplier/product low} or {remainder, quotient}.
  logic [32:0] add_sum, rem_sh, rem_diff;
  logic        neg;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign rem_sh   = {acc_q[63:32], acc_q[31]};
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign neg      = sgn_a_q ^ sgn_b_q;
  assign prod_fix = neg ? -acc_q : acc_q;
  assign quo_fix  = neg ? -acc_q[31:0] : acc_q[31:0];
  assign rem_fix  = sgn_a_q ? -acc_q[63:32] : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sgn_a_d   = sgn_a_q;
    sgn_b_d   = sgn_b_q;
    special_d = special_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    result_d  = result_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_d      = funct3;
          sgn_a_d   = in_sgn_a;
          sgn_b_d   = in_sgn_b;
          cnt_d     = 6'd0;
          opnd_d    = is_div ? mag_b : mag_a;
          acc_d     = {32'd0, is_div ? mag_a : mag_b};
          special_d = div_zero | div_ovf;
          state_d   = (div_zero | div_ovf) ? FIX : CALC;
          // Divide-by-zero is checked first so it takes precedence.
          if (div_zero)
            result_d = funct3[1] ? rs1 : 32'hFFFF_FFFF;
          else if (div_ovf)
            result_d = funct3[1] ? 32'd0 : 32'h8000_0000;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (op_q[2]) begin
          if (!rem_diff[32])
            acc_d = {rem_diff[31:0], acc_q[30:0], 1'b1};
          else
            acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
        end else begin
          acc_d = {add_sum, acc_q[31:1]};
        end
        if (cnt_q == 6'd31)
          state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        if (!special_q) begin
          case (op_q)
            3'b000:                 result_d = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: result_d = prod_fix[63:32];
            3'b100, 3'b101:         result_d = quo_fix;
            default:                result_d = rem_fix;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 3'd0;
      sgn_a_q   <= 1'b0;
      sgn_b_q   <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= 6'd0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sgn_a_q   <= sgn_a_d;
      sgn_b_q   <= sgn_b_d;
      special_q <= special_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q == CALC) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed-vector bench for mdu_unit: results, latency, busy length,
// back-to-back issue, ignored mid-flight start and reset abort.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge E0
  // with the operand inputs scrambled.
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; funct3 = ~f; rs1 = $urandom; rs2 = $urandom;
  endtask

  task automatic wait_done(input string tag, output logic [31:0] res,
                           output int lat, output int busy_cnt);
    lat = 0; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    res = result;
  endtask

  task automatic run_case(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int lat, bc;
    launch(f, a, b);
    wait_done(tag, res, lat, bc);
    check({tag, " result"}, res, exp);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy"}, 32'(bc), 32'(exp_lat));
    $display("[TB] %s f=%b res=%h lat=%0d busy=%0d", tag, f, res, lat, bc);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] res;
    int lat, bc, dcount;
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);

    // MUL with single-cycle done check
    launch(3'b000, 32'd7, 32'hFFFF_FFFD);
    wait_done("mul", res, lat, bc);
    check("mul result", res, 32'hFFFF_FFEB);
    check("mul latency", 32'(lat), 32'd33);
    check("mul busy", 32'(bc), 32'd33);
    $display("[TB] mul res=%h lat=%0d busy=%0d", res, lat, bc);
    @(negedge clk);
    check("mul done pulse", 32'(done), 32'd0);
    check("mul result hold", result, 32'hFFFF_FFEB);

    run_case("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_case("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_case("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_case("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_case("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_case("divu",   3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
    run_case("div0",   3'b100, 32'h0000_0055, 32'd0, 32'hFFFF_FFFF, 1);
    run_case("remu0",  3'b111, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
    run_case("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_case("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // Back-to-back: start DIVU during the done cycle of a MUL
    launch(3'b000, 32'd6, 32'd9);
    wait_done("b2b mul", res, lat, bc);
    check("b2b mul result", res, 32'd54);
    launch(3'b101, 32'd100, 32'd7);
    check("b2b done fall", 32'(done), 32'd0);
    check("b2b busy rise", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midcalc start busy", 32'(busy), 32'd1);
    wait_done("b2b divu", res, lat, bc);
    check("b2b divu result", res, 32'd14);
    check("b2b divu latency", 32'(lat), 32'd22);
    $display("[TB] b2b divu res=%h lat=%0d", res, lat);
    @(negedge clk);

    // Reset at iteration 10 of a DIV
    launch(3'b100, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", 32'(busy), 32'd0);
    check("rst result", result, 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    check("rst no done", 32'(dcount), 32'd0);
    $display("[TB] reset abort busy=%0d result=%h dones=%0d", busy, result, dcount);

    // rst and start in the same cycle: reset wins
    rst = 1'b1; start = 1'b1; funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd2;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst+start busy", 32'(busy), 32'd0);
    $display("[TB] rst+start busy=%0d", busy);

    run_case("mul3x5", 3'b000, 32'd3, 32'd5, 32'd15, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Iterative RV32M multiply/divide unit in the execute stage, directly upstream of the write-back stage. It takes `rs1`/`rs2` operands and a `funct3` opcode, runs a multi-cycle shift-add or restoring-divide sequence, and presents a 32-bit `result` with a one-cycle `done` pulse. The control unit stalls the pipeline while `busy` is high. It then routes `result` onto the ALU-result path consumed by the write-back mux and data-memory address input.

## Interface
- No parameters. Data width is fixed at 32.
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `start`  input  1  request. Sampled only when state is IDLE or DONE; ignored otherwise.
- `funct3`  input  3  opcode: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`  input  32  dividend or multiplicand. Sampled with `start`.
- `rs2`  input  32  divisor or multiplier. Sampled with `start`.
- `busy`  output  1  high while in CALC or FIX.
- `done`  output  1  high for exactly one cycle (DONE state); `result` is valid.
- `result`  output  32  registered result. Held stable from `done` until the next accepted `start`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE or DONE, with `start`:**
  - Latch `funct3`.
  - Latch operand magnitudes and signs. Signed for MULH/DIV/REM, rs1 signed and rs2 unsigned for MULHSU, unsigned otherwise.
  - Clear the 6-bit iteration counter. Go to CALC.
  - Special divide cases bypass CALC and go straight to FIX with `result` preloaded.
- **IDLE or DONE, without `start`:** DONE returns to IDLE; IDLE stays.
- **CALC, multiply:** unsigned radix-2 shift-add into a 64-bit product, one multiplier bit per cycle.
- **CALC, divide:** restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- **CALC exit:** after 32 iterations (counter reaches 31), go to FIX.
- **FIX:** apply sign correction, then select the result word. Go to DONE.
  - Product: negate the 64-bit product if the operand signs differ (signed cases only).
  - Quotient: negate if the operand signs differ.
  - Remainder: takes the sign of the dividend.
  - Select word: MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32 bits.
- **DONE:** assert `done` for one cycle.
- **Special cases**, detected at accept:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Divisor-0 wins over overflow if both apply (cannot coincide in practice).
- All arithmetic is modulo 2^32 on the output. No exceptions are raised.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0x00000000, counter 0.
- Let E0 be the edge where `start` is accepted.
- **Normal operation:**
  - `busy` = 1 after E0 through E32.
  - FIX state after E32.
  - `done` = 1 and `result` valid after E33.
  - Latency is 33 cycles from accept to `done`.
- **Special cases:** FIX after E0; `done` after E1 (latency 1).
- **Back-to-back:** `start` high during the DONE cycle is accepted. The next operation begins at that edge, and `done` falls at the same edge.
- **`start` while busy:** ignored; operands are not resampled. The in-flight operation completes unchanged.
- **`rst` mid-operation:** returns to IDLE at that edge; no `done` is produced and `result` is cleared.
- **`rst` and `start` in the same cycle:** `rst` wins.
- **Operand changes:** changes to `rs1`/`rs2`/`funct3` after E0 have no effect on the current operation.

## Test plan
- **MUL:** rs1 = 7, rs2 = 0xFFFFFFFD, funct3 = 000 → `done` after E33, `result` = 0xFFFFFFEB. `busy` is high for exactly 33 cycles.
- **MULH / MULHU / MULHSU:** rs1 = rs2 = 0xFFFFFFFF.
  - MULH → 0x00000000.
  - MULHU → 0xFFFFFFFE.
  - MULHSU → 0xFFFFFFFF.
- **DIV / REM signed:** rs1 = −7 (0xFFFFFFF9), rs2 = 2.
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU with the same operands → 0x7FFFFFFC.
- **Special cases:**
  - DIV with rs2 = 0 → 0xFFFFFFFF after E1.
  - REMU with rs1 = 0x1234, rs2 = 0 → 0x00001234.
  - DIV with 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- **Back-to-back:** assert `start` (DIVU 100 / 7) during the `done` cycle of a prior MUL. Check that `done` falls, `busy` rises next cycle, and the second `result` = 14 after 33 more cycles. A `start` pulse injected mid-CALC is ignored.
- **Reset:** assert `rst` at iteration 10 of a DIV. Check `busy` = 0, `result` = 0 and no `done` pulse. A fresh MUL of 3 × 5 then gives 15.
